// File: rtl/ddr2_read_return_collector.sv
// Host-side collector for the DDR2 read-return path: queues accepted reads, matches
// returned beats to the oldest request, checks addresses and emits one completion each.
module ddr2_read_return_collector #(
    parameter int TAG_DEPTH   = 8,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic                               CLK,
    input  logic                               RESET,
    input  logic                               REQ_VALID,
    input  logic [1:0]                         REQ_SZ,
    input  logic [24:0]                        REQ_ADDR,
    output logic                               REQ_READY,
    input  logic                               VALIDOUT,
    input  logic [15:0]                        DOUT,
    input  logic [24:0]                        RADDR,
    output logic                               FETCHING,
    output logic                               CPL_VALID,
    output logic [24:0]                        CPL_ADDR,
    output logic [5:0]                         CPL_LEN,
    output logic [15:0]                        CPL_SUM,
    output logic                               CPL_ERR,
    output logic [$clog2(TAG_DEPTH+1)-1:0]     OUTSTANDING,
    output logic                               ERR_ADDR,
    output logic                               ERR_OVERFLOW,
    output logic                               ERR_UNEXP,
    output logic                               ERR_TIMEOUT
);
    localparam int PTR_W  = $clog2(TAG_DEPTH);
    localparam int CNT_W  = $clog2(TAG_DEPTH + 1);
    localparam int IDLE_W = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [1:0] {IDLE, COLLECT, DONE} state_t;

    logic [24:0]       addr_mem [TAG_DEPTH];
    logic [1:0]        sz_mem   [TAG_DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr, rd_next;
    logic [CNT_W-1:0]  count;
    logic              full, push, pop;

    state_t            state, state_next;
    logic [24:0]       base;
    logic [5:0]        exp_len, cnt, cnt_inc;
    logic [15:0]       sum;
    logic              err;
    logic [IDLE_W-1:0] idle_cnt;

    logic              start_new, accept, fin_beat, fin_to, unexp, mismatch;
    logic [24:0]       start_addr;
    logic [1:0]        start_sz;

    function automatic logic [5:0] len_of(input logic [1:0] sz);
        return {1'b0, sz, 3'b000} + 6'd8;
    endfunction

    assign full      = (count == CNT_W'(TAG_DEPTH));
    assign rd_next   = rd_ptr + PTR_W'(1);
    assign cnt_inc   = cnt + 6'd1;
    assign mismatch  = (RADDR != base + 25'(cnt));
    // A pop in the same cycle frees a slot, so a full queue can still accept.
    assign push      = REQ_VALID && (!full || pop);

    assign REQ_READY   = !full;
    assign OUTSTANDING = count;
    assign FETCHING    = (count != '0) || (state == COLLECT);
    assign CPL_VALID   = (state == DONE);

    always_ff @(posedge CLK) begin
        if (push) begin
            addr_mem[wr_ptr] <= REQ_ADDR;
            sz_mem[wr_ptr]   <= REQ_SZ;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_next;
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) state <= IDLE;
        else       state <= state_next;
    end

    // In DONE the head is still the finished request, so a new beat belongs to the entry after it.
    always_comb begin
        state_next = state;
        start_new  = 1'b0;
        start_addr = addr_mem[rd_ptr];
        start_sz   = sz_mem[rd_ptr];
        accept     = 1'b0;
        fin_beat   = 1'b0;
        fin_to     = 1'b0;
        pop        = 1'b0;
        unexp      = 1'b0;
        case (state)
            IDLE: begin
                if (VALIDOUT) begin
                    if (count != '0) begin
                        start_new  = 1'b1;
                        state_next = COLLECT;
                    end else begin
                        unexp = 1'b1;
                    end
                end
            end
            COLLECT: begin
                if (VALIDOUT) begin
                    accept = 1'b1;
                    if (cnt_inc == exp_len) begin
                        fin_beat   = 1'b1;
                        state_next = DONE;
                    end
                end else if (idle_cnt == IDLE_W'(TIMEOUT_CYC - 1)) begin
                    fin_to     = 1'b1;
                    state_next = DONE;
                end
            end
            DONE: begin
                pop        = 1'b1;
                state_next = IDLE;
                start_addr = addr_mem[rd_next];
                start_sz   = sz_mem[rd_next];
                if (VALIDOUT) begin
                    if (count > CNT_W'(1)) begin
                        start_new  = 1'b1;
                        state_next = COLLECT;
                    end else begin
                        unexp = 1'b1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            base     <= '0;
            exp_len  <= '0;
            cnt      <= '0;
            sum      <= '0;
            err      <= 1'b0;
            idle_cnt <= '0;
        end else if (start_new) begin
            base     <= start_addr;
            exp_len  <= len_of(start_sz);
            cnt      <= 6'd1;
            sum      <= DOUT;
            err      <= (RADDR != start_addr);
            idle_cnt <= '0;
        end else if (accept) begin
            cnt      <= cnt_inc;
            sum      <= sum + DOUT;
            err      <= err | mismatch;
            idle_cnt <= '0;
        end else if (state == COLLECT) begin
            idle_cnt <= idle_cnt + IDLE_W'(1);
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            CPL_ADDR     <= '0;
            CPL_LEN      <= '0;
            CPL_SUM      <= '0;
            CPL_ERR      <= 1'b0;
            ERR_ADDR     <= 1'b0;
            ERR_OVERFLOW <= 1'b0;
            ERR_UNEXP    <= 1'b0;
            ERR_TIMEOUT  <= 1'b0;
        end else begin
            if (fin_beat) begin
                CPL_ADDR <= base;
                CPL_LEN  <= cnt_inc;
                CPL_SUM  <= sum + DOUT;
                CPL_ERR  <= err | mismatch;
            end else if (fin_to) begin
                CPL_ADDR <= base;
                CPL_LEN  <= cnt;
                CPL_SUM  <= sum;
                CPL_ERR  <= 1'b1;
            end
            if ((start_new && RADDR != start_addr) || (accept && mismatch)) ERR_ADDR <= 1'b1;
            if (REQ_VALID && !push) ERR_OVERFLOW <= 1'b1;
            if (unexp)  ERR_UNEXP   <= 1'b1;
            if (fin_to) ERR_TIMEOUT <= 1'b1;
        end
    end
endmodule

// File: tb/tb_ddr2_read_return_collector.sv
// Directed bench for ddr2_read_return_collector: hand-computed completions are queued
// and a monitor compares every CPL_VALID strobe against them in order.
module tb_ddr2_read_return_collector;

   typedef struct {
      logic [24:0] addr;
      logic [5:0]  len;
      logic [15:0] sum;
      logic        err;
   } cpl_t;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        reqValid = 1'b0;
   logic [1:0]  reqSz = '0;
   logic [24:0] reqAddr = '0;
   logic        reqReady;
   logic        validOut = 1'b0;
   logic [15:0] dout = '0;
   logic [24:0] rAddr = '0;
   logic        fetching, cplValid, cplErr;
   logic [24:0] cplAddr;
   logic [5:0]  cplLen;
   logic [15:0] cplSum;
   logic [3:0]  outstanding;
   logic        errAddr, errOverflow, errUnexp, errTimeout;

   cpl_t expQ[$];
   cpl_t monExp;
   int   checks = 0;
   int   errors = 0;
   int   waitCnt;

   ddr2_read_return_collector #(.TAG_DEPTH(8), .TIMEOUT_CYC(64)) dut (
      .CLK(clock), .RESET(reset),
      .REQ_VALID(reqValid), .REQ_SZ(reqSz), .REQ_ADDR(reqAddr), .REQ_READY(reqReady),
      .VALIDOUT(validOut), .DOUT(dout), .RADDR(rAddr), .FETCHING(fetching),
      .CPL_VALID(cplValid), .CPL_ADDR(cplAddr), .CPL_LEN(cplLen), .CPL_SUM(cplSum),
      .CPL_ERR(cplErr), .OUTSTANDING(outstanding),
      .ERR_ADDR(errAddr), .ERR_OVERFLOW(errOverflow), .ERR_UNEXP(errUnexp),
      .ERR_TIMEOUT(errTimeout)
   );

   // 10 ns controller clock
   always #5 clock = ~clock;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("[TB] FAIL %s observed 0x%0h expected 0x%0h", tag, observed, expected);
      end
   endtask

   task automatic tick;
      @(posedge clock);
      #1;
   endtask

   // Holds one cycle of inputs across the next rising edge, then drops the strobes
   task automatic applyStimulus(input logic rv, input logic [1:0] rs, input logic [24:0] ra,
                                input logic vo, input logic [15:0] d, input logic [24:0] rd);
      reqValid = rv;
      reqSz    = rs;
      reqAddr  = ra;
      validOut = vo;
      dout     = d;
      rAddr    = rd;
      tick();
      reqValid = 1'b0;
      validOut = 1'b0;
   endtask

   // Beat k of a burst carries data k+1 at address base+k (25-bit wrap)
   task automatic sendBeats(input logic [24:0] base, input int first, input int last);
      for (int k = first; k < last; k++)
         applyStimulus(1'b0, 2'b00, 25'h0, 1'b1, 16'(k + 1), base + 25'(k));
   endtask

   task automatic idleCycles(input int n);
      for (int i = 0; i < n; i++)
         applyStimulus(1'b0, 2'b00, 25'h0, 1'b0, 16'h0, 25'h0);
   endtask

   task automatic expectCpl(input logic [24:0] a, input logic [5:0] l, input logic [15:0] s, input logic e);
      cpl_t c;
      c.addr = a; c.len = l; c.sum = s; c.err = e;
      expQ.push_back(c);
   endtask

   // Every completion strobe is matched against the oldest expected completion
   always @(posedge clock) begin
      #2;
      if (!reset && cplValid) begin
         if (expQ.size() == 0) begin
            checkOutput("cpl_unexpected", 32'd1, 32'd0);
         end else begin
            monExp = expQ.pop_front();
            checkOutput("cpl_addr", 32'(cplAddr), 32'(monExp.addr));
            checkOutput("cpl_len",  32'(cplLen),  32'(monExp.len));
            checkOutput("cpl_sum",  32'(cplSum),  32'(monExp.sum));
            checkOutput("cpl_err",  32'(cplErr),  32'(monExp.err));
         end
      end
   end

   // Guarantees termination even if the DUT wedges
   initial begin
      #200000;
      $display("[TB] FAIL watchdog observed timeout expected finish");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      // Reset state
      tick(); tick();
      checkOutput("rst_req_ready", 32'(reqReady), 32'd1);
      checkOutput("rst_fetching", 32'(fetching), 32'd0);
      checkOutput("rst_outstanding", 32'(outstanding), 32'd0);
      checkOutput("rst_cpl_valid", 32'(cplValid), 32'd0);
      checkOutput("rst_errs", {28'd0, errAddr, errOverflow, errUnexp, errTimeout}, 32'd0);
      reset = 1'b0;
      tick();

      // Single 8-beat burst, sum 1..8 = 0x24
      expectCpl(25'h100, 6'd8, 16'h0024, 1'b0);
      applyStimulus(1'b1, 2'b00, 25'h100, 1'b0, 16'h0, 25'h0);
      checkOutput("t2_outstanding", 32'(outstanding), 32'd1);
      checkOutput("t2_fetching", 32'(fetching), 32'd1);
      sendBeats(25'h100, 0, 7);
      checkOutput("t2_no_early_cpl", 32'(cplValid), 32'd0);
      sendBeats(25'h100, 7, 8);
      checkOutput("t2_cpl_latency", 32'(cplValid), 32'd1);
      checkOutput("t2_cpl_sum", 32'(cplSum), 32'h24);
      idleCycles(1);
      checkOutput("t2_cpl_one_cycle", 32'(cplValid), 32'd0);
      checkOutput("t2_outstanding_after", 32'(outstanding), 32'd0);
      checkOutput("t2_len_hold", 32'(cplLen), 32'd8);

      // Back-to-back requests, gapless returns, new request during a DONE
      expectCpl(25'h1000, 6'd16, 16'h0088, 1'b0);
      expectCpl(25'h2000, 6'd8,  16'h0024, 1'b0);
      expectCpl(25'h3000, 6'd32, 16'h0210, 1'b0);
      expectCpl(25'h4000, 6'd8,  16'h0024, 1'b0);
      applyStimulus(1'b1, 2'b01, 25'h1000, 1'b0, 16'h0, 25'h0);
      applyStimulus(1'b1, 2'b00, 25'h2000, 1'b0, 16'h0, 25'h0);
      applyStimulus(1'b1, 2'b11, 25'h3000, 1'b0, 16'h0, 25'h0);
      checkOutput("t3_outstanding3", 32'(outstanding), 32'd3);
      sendBeats(25'h1000, 0, 16);
      checkOutput("t3_cpl_a", 32'(cplValid), 32'd1);
      applyStimulus(1'b1, 2'b00, 25'h4000, 1'b1, 16'd1, 25'h2000);
      checkOutput("t3_push_pop_same", 32'(outstanding), 32'd3);
      sendBeats(25'h2000, 1, 8);
      sendBeats(25'h3000, 0, 32);
      checkOutput("t3_outstanding_c", 32'(outstanding), 32'd2);
      sendBeats(25'h4000, 0, 8);
      idleCycles(1);
      checkOutput("t3_outstanding0", 32'(outstanding), 32'd0);
      checkOutput("t3_no_errs", {28'd0, errAddr, errOverflow, errUnexp, errTimeout}, 32'd0);

      // Address wrap is legal; a wrong beat address flags the request but still counts
      expectCpl(25'h1FFFFFC, 6'd8, 16'h0024, 1'b0);
      applyStimulus(1'b1, 2'b00, 25'h1FFFFFC, 1'b0, 16'h0, 25'h0);
      sendBeats(25'h1FFFFFC, 0, 8);
      idleCycles(1);
      checkOutput("t4_wrap_no_err_addr", 32'(errAddr), 32'd0);
      expectCpl(25'h100, 6'd8, 16'h0024, 1'b1);
      applyStimulus(1'b1, 2'b00, 25'h100, 1'b0, 16'h0, 25'h0);
      sendBeats(25'h100, 0, 3);
      applyStimulus(1'b0, 2'b00, 25'h0, 1'b1, 16'd4, 25'h105);
      sendBeats(25'h100, 4, 8);
      idleCycles(1);
      checkOutput("t4_err_addr", 32'(errAddr), 32'd1);

      // Fill the queue, overflow, drain, then a stray beat
      for (int i = 0; i < 8; i++)
         applyStimulus(1'b1, 2'b00, 25'h5000 + 25'(i * 16), 1'b0, 16'h0, 25'h0);
      checkOutput("t5_ready_full", 32'(reqReady), 32'd0);
      checkOutput("t5_outstanding8", 32'(outstanding), 32'd8);
      checkOutput("t5_no_overflow_yet", 32'(errOverflow), 32'd0);
      applyStimulus(1'b1, 2'b00, 25'h7777, 1'b0, 16'h0, 25'h0);
      checkOutput("t5_overflow", 32'(errOverflow), 32'd1);
      checkOutput("t5_outstanding_cap", 32'(outstanding), 32'd8);
      for (int i = 0; i < 8; i++) begin
         expectCpl(25'h5000 + 25'(i * 16), 6'd8, 16'h0024, 1'b0);
         sendBeats(25'h5000 + 25'(i * 16), 0, 8);
      end
      idleCycles(1);
      checkOutput("t5_drained", 32'(outstanding), 32'd0);
      checkOutput("t5_no_unexp_yet", 32'(errUnexp), 32'd0);
      applyStimulus(1'b0, 2'b00, 25'h0, 1'b1, 16'hAAAA, 25'h123);
      checkOutput("t5_unexp", 32'(errUnexp), 32'd1);
      checkOutput("t5_unexp_outstanding", 32'(outstanding), 32'd0);

      // Sticky errors clear on reset
      reset = 1'b1;
      tick();
      reset = 1'b0;
      checkOutput("t6_sticky_cleared", {28'd0, errAddr, errOverflow, errUnexp, errTimeout}, 32'd0);
      tick();

      // Five beats then silence: 1+2+3+4+5 = 0xF, completion after 64 idle cycles
      expectCpl(25'h600, 6'd5, 16'h000F, 1'b1);
      applyStimulus(1'b1, 2'b00, 25'h600, 1'b0, 16'h0, 25'h0);
      sendBeats(25'h600, 0, 5);
      waitCnt = 0;
      for (int i = 0; i < 200; i++) begin
         idleCycles(1);
         waitCnt++;
         if (cplValid) break;
      end
      checkOutput("t6_timeout_wait", 32'(waitCnt), 32'd64);
      checkOutput("t6_err_timeout", 32'(errTimeout), 32'd1);
      idleCycles(1);

      // Reset in the middle of a burst abandons it without a completion
      applyStimulus(1'b1, 2'b00, 25'h700, 1'b0, 16'h0, 25'h0);
      sendBeats(25'h700, 0, 3);
      validOut = 1'b1;
      dout     = 16'd4;
      rAddr    = 25'h703;
      reset    = 1'b1;
      #1;
      checkOutput("t6_rst_outstanding", 32'(outstanding), 32'd0);
      checkOutput("t6_rst_fetching", 32'(fetching), 32'd0);
      checkOutput("t6_rst_err_timeout", 32'(errTimeout), 32'd0);
      checkOutput("t6_rst_cpl_len", 32'(cplLen), 32'd0);
      tick();
      validOut = 1'b0;
      reset    = 1'b0;
      idleCycles(10);
      checkOutput("t6_no_cpl", 32'(cplValid), 32'd0);
      checkOutput("t6_ready_after", 32'(reqReady), 32'd1);
      checkOutput("cpl_all_seen", 32'(expQ.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
